// File: rtl/nbit_acc.sv
// nbit_acc: N-operand block accumulator built around one nbitfa adder.
// Optional saturating mode: define NBITACC_SAT_EN.

module nbitfa #(
    parameter int P = 6
) (
    input  logic [P-1:0] a,
    input  logic [P-1:0] b,
    input  logic         cin,
    output logic [P-1:0] s,
    output logic         cout
);
    logic [P:0] t;

    assign t    = {1'b0, a} + {1'b0, b} + (P+1)'(cin);
    assign s    = t[P-1:0];
    assign cout = t[P];
endmodule

module nbit_acc #(
    parameter int P = 6,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [P-1:0] din,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] sum_out,
    output logic         cout_out
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t        state, state_n;
    logic [P-1:0]  acc, acc_n, acc_src, s, add_v;
    logic          ovf, ovf_n, c, take;
    logic [CW-1:0] cnt, cnt_n;

    assign in_ready = (state != HOLD);
    assign take     = in_valid && in_ready;
    // A fresh block starts from zero rather than the stale result
    assign acc_src  = (state == IDLE) ? '0 : acc;

    nbitfa #(.P(P)) u_fa (
        .a   (acc_src),
        .b   (din),
        .cin (cin),
        .s   (s),
        .cout(c)
    );

`ifdef NBITACC_SAT_EN
    assign add_v = (c || (state == ACCUM && ovf)) ? '1 : s;
`else
    assign add_v = s;
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        ovf_n   = ovf;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (take) begin
                    acc_n = add_v;
                    ovf_n = c;
                    if (N == 1) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        state_n = ACCUM;
                        cnt_n   = CW'(1);
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    acc_n = add_v;
                    ovf_n = ovf | c;
                    if (cnt == CW'(N-1)) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = IDLE;
                    ovf_n   = 1'b0;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
            cnt   <= cnt_n;
        end
    end

    assign out_valid = (state == HOLD);
    assign sum_out   = acc;
    assign cout_out  = ovf;
endmodule

// File: tb/tb_nbit_acc.sv
// tb_nbit_acc: directed and random checks of nbit_acc (N=4) and an N=1 instance.
// Expected results come from an integer block-sum model.

module tb_nbit_acc;
    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout_out;
    logic [5:0] din, sum_out;
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cin, s_cout;
    logic [5:0] s_din, s_sum;

    int  total = 0;
    int  bad   = 0;
    bit  thru  = 0;
    int  pulses = 0;
    int  t_sum, nacc, cyc, last_rise;
    bit  seen, prev_ov;

    nbit_acc #(.P(6), .N(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .cout_out(cout_out)
    );

    nbit_acc #(.P(6), .N(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din(s_din), .cin(s_cin),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum_out(s_sum), .cout_out(s_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_sum(input int t);
`ifdef NBITACC_SAT_EN
        return (t >= 64) ? 63 : t % 64;
`else
        return t % 64;
`endif
    endfunction

    // Model: a block result is the plain integer sum of its N operands
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            t_sum = 0; nacc = 0; seen = 0; prev_ov = 0;
        end else begin
            if (nacc == 4 && !seen) begin
                chk("lat", int'(out_valid), 1);
                if (out_valid) begin
                    chk("sum", int'(sum_out), exp_sum(t_sum));
                    chk("cout", int'(cout_out), int'(t_sum >= 64));
                    seen = 1;
                end
            end
            if (out_valid) begin
                chk("hold_rdy", int'(in_ready), 0);
                chk("hold_sum", int'(sum_out), exp_sum(t_sum));
                chk("hold_cnt", nacc, 4);
            end
            if (!thru) last_rise = -1;
            else if (out_valid && !prev_ov) begin
                if (last_rise >= 0) chk("period", cyc - last_rise, 5);
                last_rise = cyc;
                pulses++;
            end
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                t_sum = 0; nacc = 0; seen = 0;
            end else if (in_valid && in_ready) begin
                t_sum += int'(din) + int'(cin);
                nacc++;
            end
        end
    end

    task automatic put(input logic [5:0] d, input logic c);
        int k = 0;
        din = d; cin = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) chk("put_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; din = 0; cin = 0; out_ready = 0;
        s_in_valid = 0; s_din = 0; s_cin = 0; s_out_ready = 0;
        #1;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_sum", int'(sum_out), 0);
        chk("rst_cout", int'(cout_out), 0);
        chk("rst_rdy", int'(in_ready), 1);
        chk("rst_ov1", int'(s_out_valid), 0);
        chk("rst_rdy1", int'(s_in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        put(6'd1, 1); put(6'd2, 0); put(6'd3, 0); put(6'd4, 0);
        @(negedge clk);
        chk("t1_ov", int'(out_valid), 1);
        chk("t1_sum", int'(sum_out), 11);
        chk("t1_cout", int'(cout_out), 0);
        take();

        put(6'd63, 0); put(6'd1, 0); put(6'd0, 0); put(6'd0, 0);
        @(negedge clk);
`ifdef NBITACC_SAT_EN
        chk("t2_sum", int'(sum_out), 63);
`else
        chk("t2_sum", int'(sum_out), 0);
`endif
        chk("t2_cout", int'(cout_out), 1);
        take();

        put(6'd10, 0); put(6'd20, 0); put(6'd30, 0); put(6'd0, 0);
        repeat (5) begin
            in_valid = 1'b1;
            din = 6'($urandom);
            @(negedge clk);
            chk("t3_ov", int'(out_valid), 1);
            chk("t3_rdy", int'(in_ready), 0);
            chk("t3_sum", int'(sum_out), 60);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        take();

        put(6'd5, 0); put(6'd3, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t4_ov", int'(out_valid), 0);
        chk("t4_sum", int'(sum_out), 0);
        chk("t4_cout", int'(cout_out), 0);
        chk("t4_rdy", int'(in_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        put(6'd1, 0); put(6'd1, 0); put(6'd1, 0); put(6'd1, 0);
        @(negedge clk);
        chk("t4_sum2", int'(sum_out), 4);
        chk("t4_cout2", int'(cout_out), 0);
        take();

        thru = 1;
        din = 6'd1; cin = 0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (23) @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0; thru = 0;
        chk("t5_pulses", pulses, 4);

        for (int i = 0; i < 3; i++) begin
            s_din = 6'b010101; s_cin = 1'b1; s_in_valid = 1'b1;
            @(posedge clk);
            #1 s_in_valid = 1'b0;
            @(negedge clk);
            chk("t6_ov", int'(s_out_valid), 1);
            chk("t6_rdy", int'(s_in_ready), 0);
            chk("t6_sum", int'(s_sum), 22);
            chk("t6_cout", int'(s_cout), 0);
            s_out_ready = 1'b1;
            @(posedge clk);
            #1 s_out_ready = 1'b0;
            @(negedge clk);
            chk("t6_idle", int'(s_out_valid), 0);
            @(posedge clk);
            #1;
        end

        repeat (400) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom % 4) != 0;
            din       = 6'($urandom);
            cin       = 1'($urandom);
            out_ready = 1'($urandom);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nbit_acc.md
# nbit_acc

Sequential accumulator directly downstream of the `nbitfa` N-bit full adder. It accepts a stream of P-bit operands with carry-in over a valid/ready handshake and sums each operand into a registered accumulator using an `nbitfa` instance. After N operands it presents the block result with a sticky carry-out flag, then waits for the consumer to take it.

## Interface
- `P`, default 6: operand and accumulator width in bits.
- `N`, default 4: operands per block, N ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `din`/`cin` hold a valid operand.
- `in_ready`  out  1  block can accept an operand.
- `din`  in  P  operand.
- `cin`  in  1  carry-in added together with `din`.
- `out_valid`  out  1  `sum_out`/`cout_out` hold a completed block result.
- `out_ready`  in  1  consumer takes the result.
- `sum_out`  out  P  accumulated sum.
- `cout_out`  out  1  sticky carry/overflow for the block.

## Operation
- Internal add: `{c, s} = acc_src + din + cin` through one `nbitfa` instance of width P.
  - `acc_src` is 0 in IDLE and the `acc` register in ACCUM.
- States:
  - IDLE: accumulator logically empty.
  - ACCUM: collecting operands.
  - HOLD: result presented.
- `in_ready` is combinational: 1 in IDLE and ACCUM, 0 in HOLD.
- An operand is accepted on a rising edge where `in_valid && in_ready`.
- On each accepted operand:
  - `acc <= s`, wrapping modulo 2^P.
  - `ovf <= ovf | c`; in IDLE, `ovf <= c`.
  - The count register `cnt` increments.
  - `cnt` width is max(1, clog2(N)).
- Transitions:
  - IDLE, accept, N=1 → HOLD.
  - IDLE, accept, N>1 → ACCUM, with `cnt` = 1.
  - ACCUM, accept while `cnt` = N-1 → HOLD, with `cnt` cleared.
  - ACCUM, other accept → ACCUM.
  - HOLD, `out_ready` = 1 → IDLE, clearing `ovf` and `cnt`.
  - No accept, or HOLD with `out_ready` = 0 → state holds.
- Outputs:
  - `out_valid` = 1 only in HOLD.
  - `sum_out` = `acc` and `cout_out` = `ovf` in every state.
  - Consumers sample them only while `out_valid` = 1.
- `in_valid` in HOLD is ignored; the operand is not consumed.
- `din`/`cin` are don't-care when `in_valid` = 0.

## Timing
- Reset values, asserted asynchronously:
  - `acc` = 0, `ovf` = 0, `cnt` = 0, state = IDLE.
  - `out_valid` = 0, `sum_out` = 0, `cout_out` = 0.
  - `in_ready` = 1 (derived from IDLE).
- Reset mid-block discards all partial sums; the next accepted operand starts a fresh block.
- Latency: `out_valid` rises the cycle after the edge that accepts the Nth operand.
- Result handshake completes on the edge with `out_valid && out_ready`:
  - `out_valid` falls and `in_ready` rises in the following cycle.
  - `sum_out` keeps the old value until the next accept.
- Throughput with `in_valid` and `out_ready` held at 1: one result per N+1 cycles.
  - The HOLD cycle always costs one bubble.
- `out_ready` asserted outside HOLD has no effect.

## Configuration
- `NBITACC_SAT_EN` defined: saturating mode.
  - When an accepted add gives `c` = 1, `acc` loads all-ones instead of `s`.
  - `acc` stays all-ones for the rest of the block, ignoring further adds.
  - `ovf` is set as in wrap mode.
- `NBITACC_SAT_EN` not defined: modular wrap as described in Operation.

## Test plan
All scenarios use P=6, N=4.
- Reset, then operands (`din`, `cin`) = (000001, 1), (000010, 0), (000011, 0), (000100, 0).
  - `out_valid` rises one cycle after the 4th accept.
  - `sum_out` = 001011, `cout_out` = 0.
- Operands 111111, 000001, 000000, 000000, all with `cin` = 0.
  - Without the macro: `sum_out` = 000000, `cout_out` = 1.
  - With `NBITACC_SAT_EN`: `sum_out` = 111111, `cout_out` = 1.
- Complete a block, then hold `out_ready` = 0 for 5 cycles with `in_valid` = 1 and changing `din`.
  - `out_valid` = 1, `in_ready` = 0, and `sum_out` stays stable.
  - No operand is accepted until `out_ready` = 1.
- Accept 2 operands (000101, 000011), assert `rst` asynchronously mid-cycle, then release it.
  - Outputs are immediately at their reset values.
  - Operands 1, 1, 1, 1 with `cin` = 0 then give `sum_out` = 000100.
- Hold `in_valid` = 1 and `out_ready` = 1 with `din` = 000001 constant.
  - Results 000100 appear every 5 cycles.
  - Exactly 4 accepts occur between consecutive `out_valid` pulses.
- Parameter N=1 (P=6): every accepted operand (`din` = 010101, `cin` = 1) goes straight to HOLD.
  - `sum_out` = 010110, `cout_out` = 0.
